snn_potential_accumulator: RTL and testbench

- Integrates weighted spike contributions into a vector of output-class membrane potentials over a fixed number of SNN timesteps.
- At the end of an inference window it emits the flattened potential vector with a one-cycle valid pulse.
- Sits directly upstream of the argmax stage; o_valid/o_potentials_flat connect straight to its i_valid/i_potentials_flat.

---
 rtl/snn_potential_accumulator.sv | 147 ++++++++++++++
 tb/tb_snn_potential_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_potential_accumulator.sv
// Membrane-potential accumulator for an SNN output layer: integrates signed
// contributions per class over NUM_STEPS timesteps. Optional leak: SNN_ACC_LEAK_EN.
module snn_potential_accumulator #(
   parameter int VEC_LEN    = 3,
   parameter int DATA_W     = 48,
   parameter int WEIGHT_W   = 16,
   parameter int NUM_STEPS  = 16,
   parameter int LEAK_SHIFT = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [$clog2(VEC_LEN)-1:0]  i_class,
   input  logic [WEIGHT_W-1:0]         i_weight,
   input  logic                        i_step_end,
   output logic                        o_busy,
   output logic                        o_err,
   output logic                        o_valid,
   output logic [VEC_LEN*DATA_W-1:0]   o_potentials_flat
);

   // state | meaning
   // IDLE  | waiting for i_start; last window's potentials held
   // ACCUM | accepting contribution beats
   // LEAK  | one-cycle decay of every potential after a step (leak build only)
   // DONE  | o_valid pulse, potentials final

   localparam int CLS_W = $clog2(VEC_LEN);
   localparam int CNT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
`ifdef SNN_ACC_LEAK_EN
   localparam logic [1:0] S_LEAK  = 2'd2;
`endif
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic signed [DATA_W-1:0] POT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] POT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]         LAST_STEP = CNT_W'(NUM_STEPS - 1);

   if (VEC_LEN < 2 || WEIGHT_W >= DATA_W || NUM_STEPS < 1 ||
       LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_W) begin : g_param_check
      $error("snn_potential_accumulator: illegal parameter combination");
   end

   logic [1:0]               state, state_nxt;
   logic signed [DATA_W-1:0] pot     [VEC_LEN];
   logic signed [DATA_W-1:0] pot_nxt [VEC_LEN];
   logic [CNT_W-1:0]         step_cnt, step_cnt_nxt;
   logic                     err_q, err_nxt;
   logic                     accept, class_bad, last_step;
   logic signed [DATA_W-1:0] weight_ext;

   // One extra bit of headroom; differing top two bits means overflow.
   function automatic logic signed [DATA_W-1:0] sat_add(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [DATA_W:0] s;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      if (s[DATA_W] != s[DATA_W-1])
         sat_add = s[DATA_W] ? POT_MIN : POT_MAX;
      else
         sat_add = s[DATA_W-1:0];
   endfunction

   assign accept     = i_valid && o_ready;
   assign class_bad  = {1'b0, i_class} >= (CLS_W+1)'(VEC_LEN);
   assign last_step  = (step_cnt == LAST_STEP);
   assign weight_ext = {{(DATA_W-WEIGHT_W){i_weight[WEIGHT_W-1]}}, i_weight};

   always_comb begin
      state_nxt    = state;
      step_cnt_nxt = step_cnt;
      err_nxt      = 1'b0;
      for (int k = 0; k < VEC_LEN; k++) pot_nxt[k] = pot[k];

      case (state)
         S_IDLE: begin
            if (i_start) begin
               for (int k = 0; k < VEC_LEN; k++) pot_nxt[k] = '0;
               step_cnt_nxt = '0;
               state_nxt    = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               err_nxt = class_bad;
               for (int k = 0; k < VEC_LEN; k++) begin
                  if (!class_bad && i_class == CLS_W'(k))
                     pot_nxt[k] = sat_add(pot[k], weight_ext);
               end
               if (i_step_end) begin
`ifdef SNN_ACC_LEAK_EN
                  state_nxt = S_LEAK;
`else
                  if (last_step) state_nxt = S_DONE;
                  else           step_cnt_nxt = step_cnt + 1'b1;
`endif
               end
            end
         end
`ifdef SNN_ACC_LEAK_EN
         // Subtracting a same-signed fraction moves toward zero, so no clamp.
         S_LEAK: begin
            for (int k = 0; k < VEC_LEN; k++)
               pot_nxt[k] = pot[k] - (pot[k] >>> LEAK_SHIFT);
            if (last_step) begin
               state_nxt = S_DONE;
            end else begin
               step_cnt_nxt = step_cnt + 1'b1;
               state_nxt    = S_ACCUM;
            end
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         step_cnt <= '0;
         err_q    <= 1'b0;
         for (int k = 0; k < VEC_LEN; k++) pot[k] <= '0;
      end else begin
         state    <= state_nxt;
         step_cnt <= step_cnt_nxt;
         err_q    <= err_nxt;
         for (int k = 0; k < VEC_LEN; k++) pot[k] <= pot_nxt[k];
      end
   end

   assign o_ready = (state == S_ACCUM);
   assign o_busy  = (state != S_IDLE);
   assign o_valid = (state == S_DONE);
   assign o_err   = err_q;

   for (genvar g = 0; g < VEC_LEN; g++) begin : g_flat
      assign o_potentials_flat[(g+1)*DATA_W-1 -: DATA_W] = pot[g];
   end

endmodule

// File: tb/tb_snn_potential_accumulator.sv
// Directed bench for snn_potential_accumulator: table-driven windows plus
// hand sequences for saturation, ignored start, flow control, reset and leak.
module tb_snn_potential_accumulator;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_a, start_s;
   logic         valid;
   logic [1:0]   cls;
   logic [15:0]  weight;
   logic         step_end;

   logic         ready_a, busy_a, err_a, valid_a;
   logic [143:0] flat_a;
   logic         ready_s, busy_s, err_s, valid_s;
   logic [59:0]  flat_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   snn_potential_accumulator #(
      .VEC_LEN(3), .DATA_W(48), .WEIGHT_W(16), .NUM_STEPS(2), .LEAK_SHIFT(4)
   ) dut_a (
      .clk(clk), .rst(rst), .i_start(start_a), .i_valid(valid), .o_ready(ready_a),
      .i_class(cls), .i_weight(weight), .i_step_end(step_end), .o_busy(busy_a),
      .o_err(err_a), .o_valid(valid_a), .o_potentials_flat(flat_a)
   );

   // Narrow potentials so the clamp is reachable in a few dozen beats.
   snn_potential_accumulator #(
      .VEC_LEN(3), .DATA_W(20), .WEIGHT_W(16), .NUM_STEPS(16), .LEAK_SHIFT(4)
   ) dut_s (
      .clk(clk), .rst(rst), .i_start(start_s), .i_valid(valid), .o_ready(ready_s),
      .i_class(cls), .i_weight(weight), .i_step_end(step_end), .o_busy(busy_s),
      .o_err(err_s), .o_valid(valid_s), .o_potentials_flat(flat_s)
   );

`ifdef SNN_ACC_LEAK_EN
   logic         start_l;
   logic         ready_l, busy_l, err_l, valid_l;
   logic [143:0] flat_l;

   snn_potential_accumulator #(
      .VEC_LEN(3), .DATA_W(48), .WEIGHT_W(16), .NUM_STEPS(1), .LEAK_SHIFT(4)
   ) dut_l (
      .clk(clk), .rst(rst), .i_start(start_l), .i_valid(valid), .o_ready(ready_l),
      .i_class(cls), .i_weight(weight), .i_step_end(step_end), .o_busy(busy_l),
      .o_err(err_l), .o_valid(valid_l), .o_potentials_flat(flat_l)
   );

   function automatic longint pl(int k);
      logic signed [47:0] v;
      v = flat_l[k*48 +: 48];
      return longint'(v);
   endfunction
`endif

   typedef struct {
      logic       start;
      logic       valid;
      logic [1:0] cls;
      int         weight;
      logic       step_end;
      logic       e_ready, e_busy, e_err, e_valid;
      longint     p0, p1, p2;
   } vec_t;

   function automatic vec_t mk(logic st, logic v, logic [1:0] c, int w, logic se,
                               logic r, logic b, logic e, logic vl,
                               longint p0, longint p1, longint p2);
      vec_t t;
      t.start = st; t.valid = v; t.cls = c; t.weight = w; t.step_end = se;
      t.e_ready = r; t.e_busy = b; t.e_err = e; t.e_valid = vl;
      t.p0 = p0; t.p1 = p1; t.p2 = p2;
      return t;
   endfunction

   function automatic longint pa(int k);
      logic signed [47:0] v;
      v = flat_a[k*48 +: 48];
      return longint'(v);
   endfunction

   function automatic longint ps(int k);
      logic signed [19:0] v;
      v = flat_s[k*20 +: 20];
      return longint'(v);
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [1:0] c, int w, logic se);
      valid    = v;
      cls      = c;
      weight   = 16'(w);
      step_end = se;
   endtask

   vec_t tbl[13];
   int   acc, nval;

   initial begin
      rst = 1'b1; start_a = 1'b0; start_s = 1'b0;
`ifdef SNN_ACC_LEAK_EN
      start_l = 1'b0;
`endif
      drive(1'b0, 2'd0, 0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();

      chk("reset ready", ready_a, 0);
      chk("reset busy",  busy_a,  0);
      chk("reset err",   err_a,   0);
      chk("reset valid", valid_a, 0);
      chk("reset flat_a_zero", (flat_a == '0), 1);
      chk("reset flat_s_zero", (flat_s == '0), 1);

`ifndef SNN_ACC_LEAK_EN
      //          st  v  cls  w    se   rdy bsy err vld  p0  p1  p2
      tbl[0]  = mk(1, 0, 0,    0,  0,   0,  0,  0,  0,   0,  0,  0);
      tbl[1]  = mk(0, 1, 0,    5,  0,   1,  1,  0,  0,   0,  0,  0);
      tbl[2]  = mk(0, 1, 1,    7,  0,   1,  1,  0,  0,   5,  0,  0);
      tbl[3]  = mk(0, 1, 2,   -3,  1,   1,  1,  0,  0,   5,  7,  0);
      tbl[4]  = mk(0, 1, 1,    1,  1,   1,  1,  0,  0,   5,  7, -3);
      tbl[5]  = mk(0, 0, 0,    0,  0,   0,  1,  0,  1,   5,  8, -3);
      tbl[6]  = mk(1, 0, 0,    0,  0,   0,  0,  0,  0,   5,  8, -3);
      tbl[7]  = mk(0, 1, 3,  100,  0,   1,  1,  0,  0,   0,  0,  0);
      tbl[8]  = mk(0, 1, 0,   -7,  0,   1,  1,  1,  0,   0,  0,  0);
      tbl[9]  = mk(0, 1, 3,  100,  1,   1,  1,  0,  0,  -7,  0,  0);
      tbl[10] = mk(0, 1, 1,    2,  1,   1,  1,  1,  0,  -7,  0,  0);
      tbl[11] = mk(0, 0, 0,    0,  0,   0,  1,  0,  1,  -7,  2,  0);
      tbl[12] = mk(0, 0, 0,    0,  0,   0,  0,  0,  0,  -7,  2,  0);

      for (int i = 0; i < 13; i++) begin
         start_a = tbl[i].start;
         drive(tbl[i].valid, tbl[i].cls, tbl[i].weight, tbl[i].step_end);
         chk($sformatf("row%0d ready", i), ready_a, tbl[i].e_ready);
         chk($sformatf("row%0d busy",  i), busy_a,  tbl[i].e_busy);
         chk($sformatf("row%0d err",   i), err_a,   tbl[i].e_err);
         chk($sformatf("row%0d valid", i), valid_a, tbl[i].e_valid);
         chk($sformatf("row%0d pot0",  i), pa(0),   tbl[i].p0);
         chk($sformatf("row%0d pot1",  i), pa(1),   tbl[i].p1);
         chk($sformatf("row%0d pot2",  i), pa(2),   tbl[i].p2);
         tick();
      end
      start_a = 1'b0;
      drive(1'b0, 2'd0, 0, 1'b0);

      // i_start mid-window must neither clear potentials nor rewind the step count
      start_a = 1'b1; tick(); start_a = 1'b0;
      drive(1'b1, 2'd0, 10, 1'b1); tick();
      start_a = 1'b1;
      drive(1'b1, 2'd1, 4, 1'b0); tick();
      start_a = 1'b0;
      drive(1'b1, 2'd2, 1, 1'b1); tick();
      drive(1'b0, 2'd0, 0, 1'b0);
      chk("ign_start valid", valid_a, 1);
      chk("ign_start pot0", pa(0), 10);
      chk("ign_start pot1", pa(1), 4);
      chk("ign_start pot2", pa(2), 1);
      tick();
      chk("ign_start idle", busy_a, 0);

      // i_valid held high through a whole window
      acc = 0; nval = 0;
      start_a = 1'b1;
      drive(1'b1, 2'd0, 1, 1'b1);
      for (int c = 0; c < 8; c++) begin
         if (!busy_a || valid_a) chk($sformatf("flow c%0d ready", c), ready_a, 0);
         if (ready_a) acc++;
         if (valid_a) nval++;
         tick();
         start_a = 1'b0;
      end
      drive(1'b0, 2'd0, 0, 1'b0);
      chk("flow accepted", acc, 2);
      chk("flow valid_pulses", nval, 1);
      chk("flow pot0", pa(0), 2);
`endif

      // Saturation on the 20-bit instance: range -524288 .. 524287
      start_s = 1'b1; tick(); start_s = 1'b0;
      drive(1'b1, 2'd0, 32767, 1'b0);
      repeat (16) tick();
      chk("sat pre_clamp", ps(0), 524272);
      tick();
      chk("sat pos_clamp", ps(0), 524287);
      drive(1'b1, 2'd0, 1, 1'b0); tick();
      chk("sat pos_hold", ps(0), 524287);
      drive(1'b1, 2'd0, -1, 1'b0); tick();
      chk("sat pos_minus1", ps(0), 524286);
      drive(1'b1, 2'd0, -32768, 1'b0);
      repeat (33) tick();
      chk("sat neg_clamp", ps(0), -524288);
      drive(1'b1, 2'd0, -1, 1'b0); tick();
      chk("sat neg_hold", ps(0), -524288);
      drive(1'b1, 2'd0, 1, 1'b0); tick();
      chk("sat neg_plus1", ps(0), -524287);
      chk("sat pot1_untouched", ps(1), 0);
      chk("sat still_accum", ready_s, 1);
      drive(1'b0, 2'd0, 0, 1'b0);

`ifdef SNN_ACC_LEAK_EN
      start_l = 1'b1; tick(); start_l = 1'b0;
      drive(1'b1, 2'd0, 160, 1'b1);
      chk("leak accum_ready", ready_l, 1);
      tick();
      drive(1'b0, 2'd0, 0, 1'b0);
      chk("leak ready_low", ready_l, 0);
      chk("leak no_valid_yet", valid_l, 0);
      chk("leak busy", busy_l, 1);
      tick();
      chk("leak valid", valid_l, 1);
      chk("leak pot0", pl(0), 150);
      tick();
      chk("leak idle", busy_l, 0);
`endif

      // Reset mid-window discards everything and yields no o_valid
      start_a = 1'b1; tick(); start_a = 1'b0;
      drive(1'b1, 2'd0, 9, 1'b0); tick();
      chk("rst pre_pot0", pa(0), 9);
      drive(1'b0, 2'd0, 0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst busy", busy_a, 0);
      chk("rst ready", ready_a, 0);
      chk("rst flat_a_zero", (flat_a == '0), 1);
      chk("rst sat_busy", busy_s, 0);
      nval = 0;
      drive(1'b1, 2'd0, 5, 1'b1);
      for (int c = 0; c < 5; c++) begin
         if (valid_a) nval++;
         tick();
      end
      drive(1'b0, 2'd0, 0, 1'b0);
      chk("rst no_valid", nval, 0);
      chk("rst idle_beats_ignored", pa(0), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
